// File: rtl/test_monitor.sv
// Simulation test monitor: watches a simple write bus for a pass/fail
// mailbox write and console characters, tracks elapsed run cycles, enforces
// a timeout, and buffers console bytes in a small FIFO for a downstream sink.
module test_monitor #(
  parameter int unsigned             ADDR_WIDTH   = 16,
  parameter int unsigned             DATA_WIDTH   = 16,
  parameter int unsigned             COUNT_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]   STATUS_ADDR  = ADDR_WIDTH'(16'hFFF0),
  parameter logic [ADDR_WIDTH-1:0]   CONSOLE_ADDR = ADDR_WIDTH'(16'hFFF1),
  parameter logic [DATA_WIDTH-1:0]   PASS_VALUE   = DATA_WIDTH'(1),
  parameter logic [COUNT_WIDTH-1:0]  TIMEOUT      = COUNT_WIDTH'(32'h00000FFF),
  parameter int unsigned             FIFO_DEPTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   select,
  input  logic                   write_enable,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]  write_data,
  output logic [7:0]             console_data,
  output logic                   console_valid,
  input  logic                   console_ready,
  output logic [1:0]             status,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_RUN_COUNT = TIMEOUT - COUNT_WIDTH'(1);

  state_t state_q, state_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   occupancy;

  logic in_run, accepted, status_wr, console_wr;
  logic fifo_full, pop, push_req, push_ok;

  assign in_run     = (state_q == ST_RUN);
  assign accepted   = select & write_enable;
  assign status_wr  = in_run & accepted & (address == STATUS_ADDR);
  assign console_wr = in_run & accepted & (address == CONSOLE_ADDR);

  assign fifo_full     = (occupancy == FULL_LEVEL);
  assign console_valid = (occupancy != '0);
  assign pop           = console_valid & console_ready;
  assign push_req      = console_wr;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok       = push_req & (~fifo_full | pop);

  assign status = state_q;
  assign done   = (state_q != ST_RUN);

  // Monitor state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state: a mailbox write beats a coincident timeout; terminal states hold.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (status_wr) begin
        state_d = (write_data == PASS_VALUE) ? ST_PASS : ST_FAIL;
      end else if (cycle_count == LAST_RUN_COUNT) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Run-cycle counter; the transition edge itself still counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      cycle_count <= '0;
    else if (in_run) cycle_count <= cycle_count + COUNT_WIDTH'(1);
  end

  // Console FIFO storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky record of any console byte dropped because the FIFO was full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           overflow <= 1'b0;
    else if (push_req & fifo_full & ~pop) overflow <= 1'b1;
  end

  // Head byte, forced to zero while empty so the output never shows stale data.
  always_comb begin
    console_data = '0;
    if (console_valid) console_data = fifo_mem[rd_ptr];
  end

endmodule
